// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the NOP encoding and the default reset PC.
package cpu_pkg;
    localparam int XLEN = 16;
    localparam int ALEN = 16;
    localparam logic [XLEN-1:0] NOP_INST = 16'h0000;
    localparam logic [ALEN-1:0] DEFAULT_RESET_PC = 16'h0000;
    localparam int ENTRY_W = ALEN + XLEN;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} entries between instruction memory and decode.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ENTRY_W-1:0]         din,
    output logic [ENTRY_W-1:0]         dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage is never reset; the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];
endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: issues sequential fetches over req/gnt, queues in-order responses for decode,
// and discards in-flight fetches after a control-flow redirect.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] pcF,
    output logic [15:0] instF,
    output logic        validF,
    output logic        flushD
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [15:0]        fetch_pc;
    logic [15:0]        resp_pc;
    logic [CW-1:0]      out_cnt;
    logic [CW-1:0]      drop_cnt;
    logic [CW-1:0]      q_cnt;
    logic [CW:0]        occupancy;
    logic [ENTRY_W-1:0] head;
    logic               pop;
    logic               push;
    logic               grant;
    logic               dropping;

    assign pop       = validF & ~stallF & ~redirect_valid;
    assign occupancy = {1'b0, out_cnt} + {1'b0, q_cnt} - (CW + 1)'(pop);
    assign imem_req  = ~reset & ~redirect_valid & (occupancy < (CW + 1)'(DEPTH));
    assign imem_addr = fetch_pc;
    assign grant     = imem_req & imem_gnt;
    assign dropping  = (drop_cnt != '0);
    assign push      = imem_rvalid & ~dropping & ~redirect_valid;
    assign flushD    = redirect_valid & ~reset;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ({resp_pc, imem_rdata}),
        .dout  (head),
        .count (q_cnt)
    );

    assign validF = (q_cnt != '0);
    assign pcF    = validF ? head[ENTRY_W-1:XLEN] : 16'h0000;
    assign instF  = validF ? head[XLEN-1:0]       : NOP_INST;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            out_cnt <= out_cnt + CW'(grant) - CW'(imem_rvalid);
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                // out_cnt already includes responses owed to earlier redirects, so every
                // outstanding fetch except the one returning now becomes a drop.
                drop_cnt <= out_cnt - CW'(imem_rvalid);
            end else begin
                if (grant) fetch_pc <= fetch_pc + 16'd1;
                if (imem_rvalid) begin
                    if (dropping) drop_cnt <= drop_cnt - 1'b1;
                    else          resp_pc  <= resp_pc + 16'd1;
                end
            end
        end
    end
endmodule
